// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle for the fetch/data arbiter: fetch port, data port and the shared
// single-port memory port.
interface imem_dmem_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_ready;

    logic              dm_req;
    logic              dm_we;
    logic [1:0]        dm_size;
    logic              dm_unsigned;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;
    logic              dm_ready;
    logic              dm_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_rdata;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_size, dm_unsigned, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready, dm_err,
               mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    // Requesters plus memory model side.
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_size, dm_unsigned, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready, dm_err,
               mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates instruction fetches and data loads/stores onto one single-port
// memory; data has priority, bounded by a streak limit so fetches cannot starve.
module imem_dmem_arbiter #(
    parameter int ADDR_W        = 10,
    parameter int LAT           = 1,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic               clk,
    input  logic               rst,
    imem_dmem_arbiter_if.slave bus
);
    localparam int              SW         = (MAX_DM_STREAK < 1) ? 1 : $clog2(MAX_DM_STREAK + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_DM_STREAK);
    localparam logic [2:0]      CNT_LAST   = 3'(LAT - 1);
    localparam logic [1:0]      SZ_BYTE    = 2'b00;
    localparam logic [1:0]      SZ_HALF    = 2'b01;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;      // 1 = data port owns the access
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       dm_rdata_q, dm_rdata_d;

    logic              dm_misaligned;
    logic              grant_if;
    logic              last_access;
    logic [31:0]       lane_data;
    logic [31:0]       load_val;
    logic [3:0]        strb;
    logic [31:0]       wdata_rep;

    assign dm_misaligned = ((bus.dm_size == SZ_HALF) && bus.dm_addr[0]) ||
                           (bus.dm_size[1] && (bus.dm_addr[1:0] != 2'b00));
    assign grant_if      = bus.if_req && (!bus.dm_req || (streak_q == STREAK_MAX));
    assign last_access   = (state_q == ACCESS) && (cnt_q == CNT_LAST);

    // Shifting the addressed lane down to bit 0 serves byte, half and word alike.
    assign lane_data = bus.mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_val = lane_data;
        case (size_q)
            SZ_BYTE: load_val = {{24{~uns_q & lane_data[7]}}, lane_data[7:0]};
            SZ_HALF: load_val = {{16{~uns_q & lane_data[15]}}, lane_data[15:0]};
            default: load_val = lane_data;
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign strb[gi] = (size_q == SZ_BYTE) ? (addr_q[1:0] == 2'(gi)) :
                          (size_q == SZ_HALF) ? (addr_q[1] == 1'(gi / 2)) : 1'b1;
        assign wdata_rep[8*gi +: 8] = (size_q == SZ_BYTE) ? wdata_q[7:0] :
                                      (size_q == SZ_HALF) ? wdata_q[8*(gi % 2) +: 8] :
                                                            wdata_q[8*gi +: 8];
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        size_d     = size_q;
        uns_d      = uns_q;
        we_d       = we_q;
        err_d      = err_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        streak_d   = streak_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_if) begin
                    owner_d  = 1'b0;
                    addr_d   = bus.if_addr;
                    we_d     = 1'b0;
                    err_d    = 1'b0;
                    cnt_d    = 3'd0;
                    streak_d = '0;
                    state_d  = ACCESS;
                end else if (bus.dm_req) begin
                    owner_d  = 1'b1;
                    addr_d   = bus.dm_addr;
                    size_d   = bus.dm_size;
                    uns_d    = bus.dm_unsigned;
                    we_d     = bus.dm_we;
                    wdata_d  = bus.dm_wdata;
                    err_d    = dm_misaligned;
                    cnt_d    = 3'd0;
                    // Only streaks that actually make a fetch wait are counted.
                    if (bus.if_req)
                        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
                    else
                        streak_d = '0;
                    state_d  = dm_misaligned ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 3'd0;
                    state_d = RESP;
                    if (!owner_q)
                        if_rdata_d = bus.mem_rdata;
                    else if (!we_q)
                        dm_rdata_d = load_val;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= 32'd0;
            cnt_q      <= 3'd0;
            streak_q   <= '0;
            if_rdata_q <= 32'd0;
            dm_rdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            we_q       <= we_d;
            err_q      <= err_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            streak_q   <= streak_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign bus.mem_en    = (state_q == ACCESS);
    assign bus.mem_we    = last_access && we_q;
    assign bus.mem_wstrb = (last_access && we_q) ? strb : 4'b0000;
    assign bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_wdata = wdata_rep;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_ready  = (state_q == RESP) && !owner_q;
    assign bus.dm_ready  = (state_q == RESP) && owner_q;
    assign bus.dm_err    = (state_q == RESP) && owner_q && err_q;
endmodule
